// File: rtl/pwm_conv_pkg.sv
// Shared state encoding and mode constants for the multi-channel PWM/PPM converter.
package pwm_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } conv_state_e;

    localparam logic MODE_PPM = 1'b0;
    localparam logic MODE_PWM = 1'b1;

endpackage

// File: rtl/pwm_chan_conv.sv
// One converter channel: counts high cycles per frame, latches a saturated width,
// and regenerates a PPM pulse or PWM level from the previous frame's width.
module pwm_chan_conv
    import pwm_conv_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int PULSE_LEN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             active,
    input  logic             wrap,
    input  logic             out_en,
    input  logic             sample,
    input  logic             mode,
    input  logic [CNT_W-1:0] slot,
    output logic [CNT_W-1:0] width,
    output logic             overflow,
    output logic             pulse
);

    localparam logic [CNT_W-1:0] FULL_W = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] acc_r;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] sum_s;
    logic [CNT_W:0]   pulse_end_s;
    logic             ovf_r;
    logic             pulse_r;
    logic             pulse_next_s;

    // The wrap-slot sample belongs to the frame being closed, so fold it in here.
    assign sum_s       = acc_r + {{(CNT_W-1){1'b0}}, sample};
    assign pulse_end_s = {1'b0, width_r} + (CNT_W+1)'(PULSE_LEN - 1);

    // High-cycle accumulator, restarted at every frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr || wrap) begin
            acc_r <= '0;
        end else if (active && sample) begin
            acc_r <= acc_r + CNT_W'(1);
        end else begin
            acc_r <= acc_r;
        end
    end

    // Width and overflow latch at the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r <= '0;
            ovf_r   <= 1'b0;
        end else if (clr) begin
            width_r <= '0;
            ovf_r   <= 1'b0;
        end else if (wrap) begin
            if (sum_s == FULL_W) begin
                width_r <= MAX_W;
                ovf_r   <= 1'b1;
            end else begin
                width_r <= sum_s;
                ovf_r   <= 1'b0;
            end
        end else begin
            width_r <= width_r;
            ovf_r   <= ovf_r;
        end
    end

    // Output shape for the current slot; truncation at the frame end is implicit.
    always_comb begin
        pulse_next_s = 1'b0;
        if (!out_en) begin
            pulse_next_s = 1'b0;
        end else if (mode == MODE_PPM) begin
            pulse_next_s = (width_r != '0) && (slot >= width_r) && ({1'b0, slot} <= pulse_end_s);
        end else begin
            pulse_next_s = (slot < width_r);
        end
    end

    // Registered output, one cycle behind the slot it was computed for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= pulse_next_s;
        end
    end

    assign width    = width_r;
    assign overflow = ovf_r;
    assign pulse    = pulse_r;

endmodule

// File: rtl/pwm_ppm_converter_mc.sv
// Multi-channel PWM measurement and PPM/PWM regeneration with a shared frame slot
// counter and IDLE/PRIME/RUN sequencing.
module pwm_ppm_converter_mc
    import pwm_conv_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 5,
    parameter int PULSE_LEN = 1
) (
    input  logic                    ClkFast,
    input  logic                    RstN,
    input  logic                    Enable,
    input  logic                    Mode,
    input  logic [NUM_CH-1:0]       PwmIn,
    output logic [NUM_CH-1:0]       PpmOut,
    output logic                    FrameStrobe,
    output logic [NUM_CH*CNT_W-1:0] Width,
    output logic                    Valid,
    output logic [NUM_CH-1:0]       Overflow
);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

    conv_state_e       state_r;
    conv_state_e       state_next_s;
    logic [CNT_W-1:0]  slot_r;
    logic [CNT_W-1:0]  slot_next_s;
    logic [NUM_CH-1:0] pwm_in_r;
    logic              mode_r;
    logic              valid_r;
    logic              strobe_r;
    logic              active_s;
    logic              wrap_s;
    logic              clr_s;
    logic              out_en_s;

    assign active_s = (state_r != IDLE);
    assign wrap_s   = active_s && (slot_r == LAST_SLOT);
    assign clr_s    = (state_next_s == IDLE);
    assign out_en_s = (state_r == RUN) && (state_next_s == RUN);

    // Sequencing and slot look-ahead; dropping Enable returns to IDLE from any state.
    always_comb begin
        state_next_s = state_r;
        slot_next_s  = slot_r;
        case (state_r)
            IDLE: begin
                if (Enable) begin
                    state_next_s = PRIME;
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRIME: begin
                if (!Enable) begin
                    state_next_s = IDLE;
                end else if (wrap_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PRIME;
                end
            end
            RUN: begin
                if (!Enable) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
        if ((state_next_s == IDLE) || (state_r == IDLE) || wrap_s) begin
            slot_next_s = '0;
        end else begin
            slot_next_s = slot_r + CNT_W'(1);
        end
    end

    // Shared frame registers; strobe and valid are precomputed so they are registered.
    always_ff @(posedge ClkFast or negedge RstN) begin
        if (!RstN) begin
            state_r  <= IDLE;
            slot_r   <= '0;
            pwm_in_r <= '0;
            mode_r   <= MODE_PPM;
            valid_r  <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            slot_r   <= slot_next_s;
            pwm_in_r <= PwmIn;
            mode_r   <= wrap_s ? Mode : mode_r;
            valid_r  <= (state_next_s == RUN);
            strobe_r <= (state_next_s != IDLE) && (slot_next_s == '0);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        pwm_chan_conv #(
            .FRAME_LEN (FRAME_LEN),
            .CNT_W     (CNT_W),
            .PULSE_LEN (PULSE_LEN)
        ) u_chan (
            .clk      (ClkFast),
            .rst_n    (RstN),
            .clr      (clr_s),
            .active   (active_s),
            .wrap     (wrap_s),
            .out_en   (out_en_s),
            .sample   (pwm_in_r[k]),
            .mode     (mode_r),
            .slot     (slot_r),
            .width    (Width[k*CNT_W +: CNT_W]),
            .overflow (Overflow[k]),
            .pulse    (PpmOut[k])
        );
    end

    assign Valid       = valid_r;
    assign FrameStrobe = strobe_r;

endmodule

// File: tb/tb_pwm_ppm_converter_mc.sv
// Directed bench for pwm_ppm_converter_mc: per-frame width tables with expected
// widths, pulses, strobes and flags derived from those tables.
module tb_pwm_ppm_converter_mc;

    localparam int NUM_CH    = 4;
    localparam int FRAME_LEN = 16;
    localparam int CNT_W     = 5;
    localparam int PULSE_LEN = 1;

    logic                    ClkFast = 1'b0;
    logic                    RstN;
    logic                    Enable;
    logic                    Mode;
    logic [NUM_CH-1:0]       PwmIn;
    logic [NUM_CH-1:0]       PpmOut;
    logic                    FrameStrobe;
    logic [NUM_CH*CNT_W-1:0] Width;
    logic                    Valid;
    logic [NUM_CH-1:0]       Overflow;

    int n_cmp = 0;
    int n_err = 0;
    int w_tab [16][4];
    int mode_tab [16];
    int f;
    int t;

    pwm_ppm_converter_mc #(
        .NUM_CH    (NUM_CH),
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W),
        .PULSE_LEN (PULSE_LEN)
    ) dut (
        .ClkFast     (ClkFast),
        .RstN        (RstN),
        .Enable      (Enable),
        .Mode        (Mode),
        .PwmIn       (PwmIn),
        .PpmOut      (PpmOut),
        .FrameStrobe (FrameStrobe),
        .Width       (Width),
        .Valid       (Valid),
        .Overflow    (Overflow)
    );

    always #5 ClkFast = ~ClkFast;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (frame %0d slot %0d): observed %0h expected %0h", tag, f, t, obs, exp);
        end
    endtask

    function automatic int sat(input int w);
        return (w >= FRAME_LEN) ? FRAME_LEN - 1 : w;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ppm"},    32'(PpmOut),      32'd0);
        chk({tag, "_strobe"}, 32'(FrameStrobe), 32'd0);
        chk({tag, "_width"},  32'(Width),       32'd0);
        chk({tag, "_valid"},  32'(Valid),       32'd0);
        chk({tag, "_ovf"},    32'(Overflow),    32'd0);
    endtask

    // Expected outputs in cycle (f,t); PpmOut reflects the previous slot.
    task automatic check_cycle();
        int pf;
        int pt;
        int wv;
        logic [NUM_CH-1:0]       exp_ppm;
        logic [NUM_CH*CNT_W-1:0] exp_w;
        logic [NUM_CH-1:0]       exp_ov;
        pf = (t == 0) ? f - 1 : f;
        pt = (t == 0) ? FRAME_LEN - 1 : t - 1;
        exp_ppm = '0;
        exp_w   = '0;
        exp_ov  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (pf >= 1) begin
                wv = sat(w_tab[pf-1][k]);
                if (mode_tab[pf-1] != 0) exp_ppm[k] = (pt < wv);
                else exp_ppm[k] = (wv != 0) && (pt >= wv) && (pt <= wv + PULSE_LEN - 1);
            end
            if (f >= 1) begin
                exp_w[k*CNT_W +: CNT_W] = CNT_W'(sat(w_tab[f-1][k]));
                exp_ov[k] = (w_tab[f-1][k] >= FRAME_LEN);
            end
        end
        chk("frame_strobe", 32'(FrameStrobe), 32'(t == 0));
        chk("valid",        32'(Valid),       32'(f >= 1));
        chk("width",        32'(Width),       32'(exp_w));
        chk("overflow",     32'(Overflow),    32'(exp_ov));
        chk("ppm_out",      32'(PpmOut),      32'(exp_ppm));
    endtask

    // Drive inputs for the next slot; Mode changes at slot 8 of each frame.
    task automatic drive_next();
        int nf;
        int nt;
        int mf;
        nf = (t == FRAME_LEN - 1) ? f + 1 : f;
        nt = (t == FRAME_LEN - 1) ? 0 : t + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            PwmIn[k] = (nf >= 0 && nf < 16) ? (nt < w_tab[nf][k]) : 1'b0;
        end
        mf = (t >= 8) ? f : f - 1;
        if (mf < 0) mf = 0;
        if (mf > 15) mf = 15;
        Mode = (mode_tab[mf] != 0);
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge ClkFast);
            #1;
            if (t == FRAME_LEN - 1) begin
                t = 0;
                f++;
            end else begin
                t++;
            end
            check_cycle();
            drive_next();
        end
    endtask

    task automatic clear_tables();
        for (int i = 0; i < 16; i++) begin
            mode_tab[i] = 0;
            for (int k = 0; k < NUM_CH; k++) w_tab[i][k] = 0;
        end
    endtask

    initial begin
        RstN   = 1'b0;
        Enable = 1'b0;
        Mode   = 1'b0;
        PwmIn  = '0;
        f = -1;
        t = FRAME_LEN - 1;
        #12;
        chk_all_zero("reset");
        @(negedge ClkFast);
        RstN = 1'b1;
        @(posedge ClkFast);
        #1;
        chk_all_zero("idle");

        // ch0 directed widths, ch1 stuck high, ch2 stuck low, ch3 width 5; PWM in frames 8-9.
        clear_tables();
        begin
            int ch0 [12] = '{1, 2, 7, 8, 10, 12, 15, 3, 5, 0, 16, 4};
            for (int i = 0; i < 12; i++) begin
                w_tab[i][0] = ch0[i];
                w_tab[i][1] = 16;
                w_tab[i][2] = 0;
                w_tab[i][3] = 5;
                mode_tab[i] = (i == 8 || i == 9) ? 1 : 0;
            end
        end
        w_tab[12][0] = 16;
        w_tab[12][1] = 16;
        f = -1;
        t = FRAME_LEN - 1;
        drive_next();
        Enable = 1'b1;
        run_cycles(12 * FRAME_LEN + 10);

        // Reset at slot 9 of a partially measured frame.
        RstN   = 1'b0;
        Enable = 1'b0;
        #1;
        chk_all_zero("midframe_reset");
        @(posedge ClkFast);
        @(negedge ClkFast);
        RstN  = 1'b1;
        PwmIn = '1;
        @(posedge ClkFast);
        #1;
        chk_all_zero("post_reset_idle");

        clear_tables();
        w_tab[0][0] = 6;  w_tab[0][1] = 0; w_tab[0][2] = 3;  w_tab[0][3] = 16;
        w_tab[1][0] = 9;  w_tab[1][1] = 1; w_tab[1][2] = 14; w_tab[1][3] = 0;
        w_tab[2][0] = 4;  w_tab[2][1] = 2; w_tab[2][2] = 15; w_tab[2][3] = 8;
        f = -1;
        t = FRAME_LEN - 1;
        drive_next();
        Enable = 1'b1;
        run_cycles(3 * FRAME_LEN);

        // Dropping Enable returns to IDLE on the next edge with everything cleared.
        Enable = 1'b0;
        @(posedge ClkFast);
        #1;
        chk_all_zero("disable");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_ppm_converter_mc.md
PWM_PPM_CONVERTER_MC -- requirements
Module: pwm_ppm_converter_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent channels.
REQ-002 SHALL have parameter FRAME_LEN, default 16, frame length in ClkFast cycles (range 4..256).
REQ-003 SHALL have parameter CNT_W, default 5, width counter bits; CNT_W >= clog2(FRAME_LEN)+1.
REQ-004 SHALL have parameter PULSE_LEN, default 1, PPM pulse length in cycles (range 1..FRAME_LEN-1).
REQ-005 SHALL have port ClkFast  in  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port RstN  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port Enable  in  1  run request.
REQ-008 SHALL have port Mode  in  1  output mode: 0 = PPM, 1 = PWM regenerate.
REQ-009 SHALL have port PwmIn  in  NUM_CH  PWM inputs, synchronous to ClkFast.
REQ-010 SHALL have port PpmOut  out  NUM_CH  converted outputs, registered.
REQ-011 SHALL have port FrameStrobe  out  1  one-cycle pulse on frame slot 0.
REQ-012 SHALL have port Width  out  NUM_CH*CNT_W  last latched width per channel; channel k at bits [k*CNT_W +: CNT_W].
REQ-013 SHALL have port Valid  out  1  Width/PpmOut carry measured data.
REQ-014 SHALL have port Overflow  out  NUM_CH  channel was high for the whole previous frame.

Function
REQ-015 SHALL register PwmIn once; measurement uses the registered copy.
REQ-016 SHALL run frame counter Slot 0..FRAME_LEN-1, incrementing each cycle while not IDLE, wrapping to 0.
REQ-017 SHALL assert FrameStrobe exactly when Slot==0 and state != IDLE.
REQ-018 SHALL count, per channel, the cycles within a frame in which the registered input is high.
REQ-019 SHALL latch the count, including the Slot==FRAME_LEN-1 sample, into Width on the cycle Slot wraps to 0, and SHALL clear the accumulator in the same cycle.
REQ-020 SHALL saturate a latched width of FRAME_LEN to FRAME_LEN-1 and SHALL set the channel's Overflow bit for that frame; otherwise Overflow is 0.
REQ-021 SHALL latch Mode only at frame boundaries; mid-frame changes take effect next frame.
REQ-022 PPM mode: PpmOut[k] SHALL be high for Slot in [Width_k, Width_k+PULSE_LEN-1], truncated at FRAME_LEN-1; Width_k==0 gives no pulse.
REQ-023 PWM mode: PpmOut[k] SHALL be high for Slot < Width_k.
REQ-024 SHALL produce output one full frame after the frame measured (latency = FRAME_LEN cycles, +1 for the registered output).
REQ-025 SHALL use FSM IDLE -> PRIME (Enable rises; Slot starts at 0) -> RUN (first wrap; Valid=1) -> IDLE (Enable low, any state, next edge).
REQ-026 In IDLE and PRIME, PpmOut SHALL be 0; in IDLE, Slot, accumulators, Width, Overflow SHALL be 0.
REQ-027 A PwmIn edge coincident with wrap SHALL be counted in the frame whose Slot it was sampled in.

Reset
REQ-028 RstN low SHALL force state IDLE, Slot=0, PpmOut=0, FrameStrobe=0, Width=0, Valid=0, Overflow=0, latched Mode=0, asynchronously.
REQ-029 Reset asserted mid-frame SHALL discard partial measurements; after release, operation restarts from IDLE.

Structure
REQ-030 SHALL place FSM state enum (IDLE, PRIME, RUN) and mode constants (MODE_PPM=0, MODE_PWM=1) in shared package pwm_conv_pkg.
REQ-031 SHALL implement per-channel accumulate/latch/output logic in sub-module pwm_chan_conv, generated NUM_CH times; Slot and FSM are shared in the top.

Verification (NUM_CH=4, FRAME_LEN=16, PULSE_LEN=1)
REQ-032 SHALL check ch0 widths 1,2,7,8,10,12,15,3 in successive frames, Mode=0 -> PpmOut[0] single pulse at Slot 1,2,7,8,10,12,15,3 one frame later; Width matches.
REQ-033 SHALL check ch1 held high for all 16 slots -> Width=15, Overflow[1]=1, pulse at Slot 15; ch2 held low -> Width=0, no pulse.
REQ-034 SHALL check Mode=1 with width 5 -> PpmOut high Slots 0-4; Mode toggled at Slot 8 -> change visible only from next frame.
REQ-035 SHALL check Enable rise -> FrameStrobe every 16 cycles, Valid=1 after first wrap, no PpmOut activity in PRIME.
REQ-036 SHALL check RstN low at Slot 9 -> all outputs 0 immediately (before next edge); after release and Enable, first Width reflects only the post-reset frame.
